// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default widths, wait-cycle limits and small helper functions.
package mem_pkg;

  localparam int MEM_DATA_W   = 8;
  localparam int MEM_ADDR_W   = 5;
  localparam int MEM_WAIT_DEF = 1;
  localparam int MEM_WAIT_MIN = 1;
  localparam int MEM_WAIT_MAX = 7;
  localparam int MEM_CNT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_DONE = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_WR_DONE = 3'd4
  } mem_state_e;

  // Keep an out-of-range WAIT_CYCLES inside the counter's representable range.
  function automatic int clamp_wait(input int w);
    if (w < MEM_WAIT_MIN) return MEM_WAIT_MIN;
    if (w > MEM_WAIT_MAX) return MEM_WAIT_MAX;
    return w;
  endfunction

  // Increment that sticks at the counter's all-ones value instead of wrapping.
  function automatic logic [MEM_CNT_W-1:0] sat_inc(input logic [MEM_CNT_W-1:0] c);
    return (c == {MEM_CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for the memory responder: one synchronous write port and one
// registered read port, so it maps onto block RAM. Contents are never reset.
module mem_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];
  logic [WORD_W-1:0] rd_data_q;

  // Synchronous write and registered read; a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: edge-triggered read/write requests served by a small FSM
// with a configurable wait, plus a backdoor preload port.
// Optional feature macro: MEM_RESPONDER_PARITY_EN adds an even-parity bit per
// word and flags a parity mismatch on read through mem_error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_W,
  parameter int ADDR_WIDTH  = MEM_ADDR_W,
  parameter int WAIT_CYCLES = MEM_WAIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read_enable,
  input  logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  init_enable,
  input  logic [ADDR_WIDTH-1:0] init_address,
  input  logic [DATA_WIDTH-1:0] init_data,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_data_valid,
  output logic                  mem_write_ack,
  output logic                  mem_busy,
  output logic                  mem_error
);

  localparam int WAIT_EFF = clamp_wait(WAIT_CYCLES);
  localparam logic [MEM_CNT_W-1:0] WAIT_LAST = MEM_CNT_W'(WAIT_EFF - 1);

`ifdef MEM_RESPONDER_PARITY_EN
  localparam int WORD_W = DATA_WIDTH + 1;
`else
  localparam int WORD_W = DATA_WIDTH;
`endif

  mem_state_e            state_q;
  logic [MEM_CNT_W-1:0]  cnt_q;
  logic                  rd_prev_q;
  logic                  wr_prev_q;
  logic                  armed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  ack_q;
  logic                  busy_q;
  logic                  error_q;

  logic                  rd_edge;
  logic                  wr_edge;
  logic                  any_edge;
  logic                  init_ok;
  logic                  wr_commit;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [WORD_W-1:0]     arr_wword;
  logic [WORD_W-1:0]     arr_rword;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  par_err;

  // armed_q masks the first cycle after reset so a level already high at
  // release is absorbed into the previous-enable registers, not seen as an edge.
  assign rd_edge  = armed_q & mem_read_enable  & ~rd_prev_q;
  assign wr_edge  = armed_q & mem_write_enable & ~wr_prev_q;
  assign any_edge = rd_edge | wr_edge;

  // Preload only when the FSM is idle and no request edge competes for the port.
  assign init_ok   = (state_q == ST_IDLE) & init_enable & ~any_edge;
  assign wr_commit = (state_q == ST_WR_DONE);

  assign arr_we    = wr_commit | init_ok;
  assign arr_waddr = wr_commit ? addr_q : init_address;
  assign arr_wdata = wr_commit ? data_q : init_data;

`ifdef MEM_RESPONDER_PARITY_EN
  // Even parity: the stored bit makes the XOR of the whole word zero.
  assign arr_wword = {^arr_wdata, arr_wdata};
  assign rd_data   = arr_rword[DATA_WIDTH-1:0];
  assign par_err   = ^arr_rword;
`else
  assign arr_wword = arr_wdata;
  assign rd_data   = arr_rword;
  assign par_err   = 1'b0;
`endif

  // The read address is the latched request address; it is stable throughout
  // RD_WAIT, so the registered read word is valid by the time RD_DONE is reached.
  mem_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_array (
    .clock     (clock),
    .wr_en_i   (arr_we),
    .wr_addr_i (arr_waddr),
    .wr_data_i (arr_wword),
    .rd_addr_i (addr_q),
    .rd_data_o (arr_rword)
  );

  // Request FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      rd_prev_q <= mem_read_enable;
      wr_prev_q <= mem_write_enable;
      armed_q   <= 1'b1;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_edge && wr_edge) begin
            error_q <= 1'b1;
          end else if (rd_edge) begin
            addr_q  <= mem_address;
            cnt_q   <= '0;
            state_q <= ST_RD_WAIT;
            busy_q  <= 1'b1;
          end else if (wr_edge) begin
            addr_q  <= mem_address;
            data_q  <= mem_data_in;
            cnt_q   <= '0;
            state_q <= ST_WR_WAIT;
            busy_q  <= 1'b1;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          error_q <= any_edge;
          cnt_q   <= sat_inc(cnt_q);
          if (cnt_q >= WAIT_LAST) begin
            cnt_q   <= '0;
            state_q <= (state_q == ST_RD_WAIT) ? ST_RD_DONE : ST_WR_DONE;
          end
        end
        ST_RD_DONE: begin
          error_q    <= any_edge | par_err;
          data_out_q <= rd_data;
          valid_q    <= 1'b1;
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
        end
        ST_WR_DONE: begin
          error_q <= any_edge;
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data_out   = data_out_q;
  assign mem_data_valid = valid_q;
  assign mem_write_ack  = ack_q;
  assign mem_busy       = busy_q;
  assign mem_error      = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder with a word-array reference model.
module tb_mem_responder;

  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int W   = 1;
  localparam int LAT = W + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] mem_address = '0;
  logic          mem_read_enable = 1'b0;
  logic          mem_write_enable = 1'b0;
  logic [DW-1:0] mem_data_in = '0;
  logic          init_enable = 1'b0;
  logic [AW-1:0] init_address = '0;
  logic [DW-1:0] init_data = '0;
  logic [DW-1:0] mem_data_out;
  logic          mem_data_valid;
  logic          mem_write_ack;
  logic          mem_busy;
  logic          mem_error;

  logic [DW-1:0] model [2**AW];
  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_data_in      (mem_data_in),
    .init_enable      (init_enable),
    .init_address     (init_address),
    .init_data        (init_data),
    .mem_data_out     (mem_data_out),
    .mem_data_valid   (mem_data_valid),
    .mem_write_ack    (mem_write_ack),
    .mem_busy         (mem_busy),
    .mem_error        (mem_error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    init_enable  = 1'b1;
    init_address = AW'(a);
    init_data    = d;
    step();
    init_enable  = 1'b0;
    model[a]     = d;
    $display("preload  addr=%0d data=%02h", a, d);
  endtask

  // A read must deliver exactly one valid pulse, LAT cycles after the edge.
  task automatic do_read(input int a, input string tag);
    int vcount;
    int ecount;
    logic at_lat;
    logic [DW-1:0] got;
    vcount = 0; ecount = 0; at_lat = 1'b0; got = '0;
    mem_address = AW'(a);
    mem_read_enable = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      step();
      if (i == 1) mem_read_enable = 1'b0;
      if (mem_data_valid) begin
        vcount++;
        got = mem_data_out;
        if (i == LAT) at_lat = 1'b1;
      end
      if (mem_error) ecount++;
    end
    chk({tag, ".latency"}, 32'(at_lat), 32'd1);
    chk({tag, ".pulses"}, 32'(vcount), 32'd1);
    chk({tag, ".data"}, 32'(got), 32'(model[a]));
    chk({tag, ".error"}, 32'(ecount), 32'd0);
    $display("read     addr=%0d data=%02h exp=%02h", a, got, model[a]);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input string tag);
    int acount;
    logic at_lat;
    acount = 0; at_lat = 1'b0;
    mem_address = AW'(a);
    mem_data_in = d;
    mem_write_enable = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      step();
      if (i == 1) mem_write_enable = 1'b0;
      if (mem_write_ack) begin
        acount++;
        if (i == LAT) at_lat = 1'b1;
      end
    end
    model[a] = d;
    chk({tag, ".latency"}, 32'(at_lat), 32'd1);
    chk({tag, ".pulses"}, 32'(acount), 32'd1);
    $display("write    addr=%0d data=%02h", a, d);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".data_out"}, 32'(mem_data_out), 32'd0);
    chk({tag, ".valid"}, 32'(mem_data_valid), 32'd0);
    chk({tag, ".ack"}, 32'(mem_write_ack), 32'd0);
    chk({tag, ".busy"}, 32'(mem_busy), 32'd0);
    chk({tag, ".error"}, 32'(mem_error), 32'd0);
  endtask

  initial begin
    int cnt;
    int a;
    logic [DW-1:0] d;
    logic [DW-1:0] got;

    // Reset state
    repeat (3) step();
    chk_outputs_zero("reset");
    $display("reset    outputs checked");
    reset = 1'b1;
    step();

    // Preload every word; fixed values where directed tests depend on them
    for (int i = 0; i < 2**AW; i++) begin
      d = DW'($urandom);
      if (i == 3) d = 8'h2A;
      if (i == 31) d = 8'hA0;
      preload(i, d);
    end

    // Preloaded word read back with the nominal latency
    do_read(3, "rd3");

    // Write then read back the new value
    do_write(7, 8'h7F, "wr7");
    do_read(7, "rd7");

    // Simultaneous read/write edges: one error, no access
    mem_address = 5'd7; mem_data_in = 8'h11;
    mem_read_enable = 1'b1; mem_write_enable = 1'b1;
    step();
    chk("both.error", 32'(mem_error), 32'd1);
    chk("both.busy", 32'(mem_busy), 32'd0);
    mem_read_enable = 1'b0; mem_write_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (mem_data_valid || mem_write_ack || mem_error) cnt++;
    end
    chk("both.quiet", 32'(cnt), 32'd0);
    $display("both     edges same cycle, error checked");
    do_read(7, "both.rd7");

    // Read enable held high for 5 cycles: a single completion
    mem_address = 5'd12;
    mem_read_enable = 1'b1;
    cnt = 0; got = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 5) mem_read_enable = 1'b0;
      if (mem_data_valid) begin cnt++; got = mem_data_out; end
    end
    chk("hold.pulses", 32'(cnt), 32'd1);
    chk("hold.data", 32'(got), 32'(model[12]));
    $display("hold     addr=12 pulses=%0d data=%02h", cnt, got);

    // Write edge and preload while a read is in flight: error, read unaffected
    mem_address = 5'd9;
    mem_read_enable = 1'b1;
    step();
    mem_read_enable = 1'b0;
    mem_write_enable = 1'b1;
    mem_data_in = ~model[9];
    init_enable = 1'b1; init_address = 5'd9; init_data = ~model[9];
    step();
    init_enable = 1'b0;
    chk("busy.error", 32'(mem_error), 32'd1);
    for (int i = 3; i <= LAT; i++) step();
    chk("busy.valid", 32'(mem_data_valid), 32'd1);
    chk("busy.data", 32'(mem_data_out), 32'(model[9]));
    mem_write_enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (mem_write_ack || mem_error) cnt++;
    end
    chk("busy.no_write", 32'(cnt), 32'd0);
    $display("busy     edge during read, error checked");
    do_read(9, "busy.rd9");

    // Reset during WR_WAIT aborts the write
    mem_address = 5'd31; mem_data_in = 8'h55;
    mem_write_enable = 1'b1;
    step();
    mem_write_enable = 1'b0;
    chk("abort.busy", 32'(mem_busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_outputs_zero("abort");
    step();
    step();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (mem_write_ack || mem_data_valid || mem_busy) cnt++;
    end
    chk("abort.quiet", 32'(cnt), 32'd0);
    $display("abort    reset during write to 31");
    do_read(31, "abort.rd31");

    // Enable already high when reset is released is not an edge
    reset = 1'b0;
    mem_address = 5'd3;
    mem_read_enable = 1'b1;
    step();
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      if (mem_busy || mem_data_valid || mem_error) cnt++;
    end
    chk("release.no_edge", 32'(cnt), 32'd0);
    mem_read_enable = 1'b0;
    step();
    $display("release  enable high across reset release");

    // Randomized mix of reads, writes and preloads
    for (int n = 0; n < 24; n++) begin
      a = int'($urandom_range(0, 2**AW - 1));
      d = DW'($urandom);
      case ($urandom_range(0, 2))
        0: do_read(a, "rand.rd");
        1: do_write(a, d, "rand.wr");
        default: preload(a, d);
      endcase
    end
    for (int i = 0; i < 2**AW; i += 5) do_read(i, "sweep.rd");

`ifdef MEM_RESPONDER_PARITY_EN
    // Corrupted parity bit: error and valid pulse together
    preload(0, 8'h3C);
    dut.u_array.mem_q[0][DW] = ~dut.u_array.mem_q[0][DW];
    mem_address = 5'd0;
    mem_read_enable = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      step();
      if (i == 1) mem_read_enable = 1'b0;
    end
    chk("parity.valid", 32'(mem_data_valid), 32'd1);
    chk("parity.error", 32'(mem_error), 32'd1);
    chk("parity.data", 32'(mem_data_out), 32'h3C);
    $display("parity   corrupted word 0 read");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
